// File: rtl/mul_arbiter.sv
// Two-port round-robin front end for one shared iterative multiplier.
// Serves one transaction at a time and aborts it if the multiplier never completes.
module mul_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   mplier0,
  input  logic [WIDTH-1:0]   mcand0,
  input  logic [WIDTH-1:0]   mplier1,
  input  logic [WIDTH-1:0]   mcand1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               rvalid0,
  output logic               rvalid1,
  output logic [2*WIDTH-1:0] result0,
  output logic [2*WIDTH-1:0] result1,
  output logic               err0,
  output logic               err1,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_multiplier,
  output logic [WIDTH-1:0]   mul_multiplicand,
  input  logic [2*WIDTH-1:0] mul_result,
  input  logic               mul_done
);

  localparam int CW = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state, w_state_next;
  logic               r_owner, w_owner;
  logic               r_last, w_last;
  logic               r_busy_seen, w_busy_seen;
  logic [CW-1:0]      r_cnt, w_cnt;
  logic               r_gnt0, r_gnt1, w_gnt0, w_gnt1;
  logic               r_rvalid0, r_rvalid1, w_rvalid0, w_rvalid1;
  logic               r_err0, r_err1, w_err0, w_err1;
  logic [2*WIDTH-1:0] r_result0, r_result1, w_result0, w_result1;
  logic               r_mul_start, w_mul_start;
  logic [WIDTH-1:0]   r_mplier, r_mcand, w_mplier, w_mcand;
  logic               w_pick;

  // Winner: the lone requester, or the port not served last when both ask.
  assign w_pick = (req0 & req1) ? ~r_last : req1;

  always_comb begin
    w_state_next = r_state;
    w_owner      = r_owner;
    w_last       = r_last;
    w_busy_seen  = r_busy_seen;
    w_cnt        = r_cnt;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    w_rvalid0    = 1'b0;
    w_rvalid1    = 1'b0;
    w_err0       = r_err0;
    w_err1       = r_err1;
    w_result0    = r_result0;
    w_result1    = r_result1;
    w_mul_start  = 1'b0;
    w_mplier     = r_mplier;
    w_mcand      = r_mcand;
    case (r_state)
      S_IDLE: begin
        if (mul_done && (req0 || req1)) begin
          w_owner      = w_pick;
          w_mplier     = w_pick ? mplier1 : mplier0;
          w_mcand      = w_pick ? mcand1 : mcand0;
          w_gnt0       = ~w_pick;
          w_gnt1       = w_pick;
          w_mul_start  = 1'b1;
          w_state_next = S_START;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_START: begin
        w_busy_seen  = 1'b0;
        w_cnt        = '0;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        w_busy_seen = r_busy_seen | ~mul_done;
        w_cnt       = r_cnt + CW'(1);
        // Completion only counts once the multiplier has been seen busy.
        if (r_busy_seen && mul_done) begin
          if (r_owner) begin
            w_result1 = mul_result;
            w_err1    = 1'b0;
            w_rvalid1 = 1'b1;
          end else begin
            w_result0 = mul_result;
            w_err0    = 1'b0;
            w_rvalid0 = 1'b1;
          end
          w_state_next = S_RESP;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          if (r_owner) begin
            w_result1 = '0;
            w_err1    = 1'b1;
            w_rvalid1 = 1'b1;
          end else begin
            w_result0 = '0;
            w_err0    = 1'b1;
            w_rvalid0 = 1'b1;
          end
          w_state_next = S_RESP;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_RESP: begin
        w_last       = r_owner;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_busy_seen <= 1'b0;
      r_cnt       <= '0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_result0   <= '0;
      r_result1   <= '0;
      r_mul_start <= 1'b0;
      r_mplier    <= '0;
      r_mcand     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_owner     <= w_owner;
      r_last      <= w_last;
      r_busy_seen <= w_busy_seen;
      r_cnt       <= w_cnt;
      r_gnt0      <= w_gnt0;
      r_gnt1      <= w_gnt1;
      r_rvalid0   <= w_rvalid0;
      r_rvalid1   <= w_rvalid1;
      r_err0      <= w_err0;
      r_err1      <= w_err1;
      r_result0   <= w_result0;
      r_result1   <= w_result1;
      r_mul_start <= w_mul_start;
      r_mplier    <= w_mplier;
      r_mcand     <= w_mcand;
    end
  end

  assign gnt0             = r_gnt0;
  assign gnt1             = r_gnt1;
  assign rvalid0          = r_rvalid0;
  assign rvalid1          = r_rvalid1;
  assign err0             = r_err0;
  assign err1             = r_err1;
  assign result0          = r_result0;
  assign result1          = r_result1;
  assign mul_start        = r_mul_start;
  assign mul_multiplier   = r_mplier;
  assign mul_multiplicand = r_mcand;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a 17-busy-cycle multiplier model
// (busy_cnt loaded on mul_start, mul_done = idle).
module tb_mul_arbiter;

  logic        clock;
  logic        reset_n;
  logic        req0, req1;
  logic [31:0] mplier0, mcand0, mplier1, mcand1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mul_start;
  logic [63:0] result0, result1;
  logic [31:0] mul_multiplier, mul_multiplicand;
  logic [63:0] mul_result;
  logic        mul_done;

  logic        hold_busy;
  logic        no_drop;
  int          busy_cnt;
  logic [63:0] prod;

  int n_vec;
  int n_err;

  mul_arbiter #(.WIDTH(32), .TIMEOUT(255)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1),
    .mplier0(mplier0), .mcand0(mcand0), .mplier1(mplier1), .mcand1(mcand1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .result0(result0), .result1(result1), .err0(err0), .err1(err1),
    .mul_start(mul_start), .mul_multiplier(mul_multiplier),
    .mul_multiplicand(mul_multiplicand), .mul_result(mul_result),
    .mul_done(mul_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Multiplier model: no_drop makes it ignore starts and never go busy.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_cnt <= 0;
      prod     <= 64'd0;
    end else if (mul_start && !no_drop) begin
      busy_cnt <= 17;
      prod     <= 64'(mul_multiplier) * 64'(mul_multiplicand);
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign mul_done   = !hold_busy && (busy_cnt == 0);
  assign mul_result = prod;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; hold_busy = 1'b0; no_drop = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; hold_busy = 1'b0; no_drop = 1'b0;
    mplier0 = 32'd0; mcand0 = 32'd0; mplier1 = 32'd0; mcand1 = 32'd0;
    repeat (3) tick();
    n_vec++;
    if ({gnt0, gnt1, rvalid0, rvalid1, err0, err1, mul_start} !== 7'd0) begin
      n_err++; $display("FAIL reset_strobes: got %b want 0000000", {gnt0, gnt1, rvalid0, rvalid1, err0, err1, mul_start});
    end
    n_vec++;
    if ({result0, result1} !== 128'd0) begin
      n_err++; $display("FAIL reset_results: got %0h/%0h want 0/0", result0, result1);
    end
    n_vec++;
    if ({mul_multiplier, mul_multiplicand} !== 64'd0) begin
      n_err++; $display("FAIL reset_operands: got %0d/%0d want 0/0", mul_multiplier, mul_multiplicand);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    int g_t, r_t, n_g, n_s;
    bit got;
    do_reset();
    mplier0 = 32'd35; mcand0 = 32'd17; req0 = 1'b1;
    g_t = -1; r_t = -1; n_g = 0; n_s = 0; got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      tick();
      if (gnt0) begin
        n_g++; g_t = c; req0 = 1'b0;
        n_vec++;
        if (mul_start !== 1'b1) begin n_err++; $display("FAIL single_start_with_gnt: mul_start=%b want 1", mul_start); end
      end
      if (mul_start) n_s++;
      if (rvalid0) begin got = 1'b1; r_t = c; end
    end
    n_vec++;
    if (got !== 1'b1) begin n_err++; $display("FAIL single_rvalid_seen: got %b want 1", got); end
    n_vec++;
    if (r_t - g_t !== 19) begin n_err++; $display("FAIL single_latency: got %0d want 19", r_t - g_t); end
    n_vec++;
    if (result0 !== 64'd595) begin n_err++; $display("FAIL single_result0: got %0d want 595", result0); end
    n_vec++;
    if (err0 !== 1'b0) begin n_err++; $display("FAIL single_err0: got %b want 0", err0); end
    n_vec++;
    if (n_g !== 1) begin n_err++; $display("FAIL single_gnt_pulses: got %0d want 1", n_g); end
    n_vec++;
    if (n_s !== 1) begin n_err++; $display("FAIL single_start_pulses: got %0d want 1", n_s); end
    n_vec++;
    if ({mul_multiplier, mul_multiplicand} !== {32'd35, 32'd17}) begin
      n_err++; $display("FAIL single_operands_in_resp: got %0d/%0d want 35/17", mul_multiplier, mul_multiplicand);
    end
    n_vec++;
    if (result1 !== 64'd0) begin n_err++; $display("FAIL single_result1_untouched: got %0d want 0", result1); end
  endtask

  task automatic test_both();
    int first, g1, r0, r1;
    bit both_gnt;
    logic [63:0] res0, res1;
    do_reset();
    mplier0 = 32'd35; mcand0 = 32'd63; mplier1 = 32'd17; mcand1 = 32'd35;
    req0 = 1'b1; req1 = 1'b1;
    first = -1; g1 = -1; r0 = -1; r1 = -1; both_gnt = 1'b0; res0 = 64'd0; res1 = 64'd0;
    for (int c = 0; c < 120 && r1 < 0; c++) begin
      tick();
      if (gnt0 && gnt1) both_gnt = 1'b1;
      if ((gnt0 || gnt1) && first < 0) first = gnt1 ? 1 : 0;
      if (gnt0) req0 = 1'b0;
      if (gnt1) begin g1 = c; req1 = 1'b0; end
      if (rvalid0) begin r0 = c; res0 = result0; end
      if (rvalid1) begin r1 = c; res1 = result1; end
    end
    n_vec++;
    if (first !== 0) begin n_err++; $display("FAIL both_first_port: got %0d want 0", first); end
    n_vec++;
    if (both_gnt !== 1'b0) begin n_err++; $display("FAIL both_gnt_overlap: got %b want 0", both_gnt); end
    n_vec++;
    if (!(r0 >= 0 && g1 > r0)) begin n_err++; $display("FAIL both_gnt1_after_rvalid0: gnt1 at %0d rvalid0 at %0d", g1, r0); end
    n_vec++;
    if (res0 !== 64'd2205) begin n_err++; $display("FAIL both_result0: got %0d want 2205", res0); end
    n_vec++;
    if (res1 !== 64'd595) begin n_err++; $display("FAIL both_result1: got %0d want 595", res1); end
    n_vec++;
    if (result0 !== 64'd2205) begin n_err++; $display("FAIL both_result0_held: got %0d want 2205", result0); end
  endtask

  task automatic test_round_robin();
    int order[4];
    int exp_order[4];
    int ng, nr;
    exp_order = '{0, 1, 0, 1};
    order = '{-1, -1, -1, -1};
    do_reset();
    mplier0 = 32'd3; mcand0 = 32'd5; mplier1 = 32'd7; mcand1 = 32'd11;
    req0 = 1'b1; req1 = 1'b1; ng = 0; nr = 0;
    for (int c = 0; c < 200 && nr < 4; c++) begin
      tick();
      if (gnt0 || gnt1) begin
        if (ng < 4) order[ng] = gnt1 ? 1 : 0;
        ng++;
        if (ng == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
      if (rvalid0) begin
        nr++; n_vec++;
        if (result0 !== 64'd15) begin n_err++; $display("FAIL rr_result0: got %0d want 15", result0); end
      end
      if (rvalid1) begin
        nr++; n_vec++;
        if (result1 !== 64'd77) begin n_err++; $display("FAIL rr_result1: got %0d want 77", result1); end
      end
    end
    n_vec++;
    if (nr !== 4) begin n_err++; $display("FAIL rr_responses: got %0d want 4", nr); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (order[i] !== exp_order[i]) begin
        n_err++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int g_t, r_t, k;
    bit got;
    do_reset();
    no_drop = 1'b1;
    mplier0 = 32'd9; mcand0 = 32'd9; req0 = 1'b1;
    g_t = -1; r_t = -1; got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      tick();
      if (gnt0) begin g_t = c; req0 = 1'b0; end
      if (rvalid0) begin got = 1'b1; r_t = c; end
    end
    n_vec++;
    if (r_t - g_t !== 256) begin n_err++; $display("FAIL timeout_latency: got %0d want 256", r_t - g_t); end
    n_vec++;
    if (err0 !== 1'b1) begin n_err++; $display("FAIL timeout_err0: got %b want 1", err0); end
    n_vec++;
    if (result0 !== 64'd0) begin n_err++; $display("FAIL timeout_result0: got %0d want 0", result0); end
    no_drop = 1'b0;
    mplier1 = 32'd4; mcand1 = 32'd4; req1 = 1'b1;
    k = -1;
    for (int c = 1; c <= 5 && k < 0; c++) begin
      tick();
      if (gnt1) begin k = c; req1 = 1'b0; end
    end
    n_vec++;
    if (k !== 2) begin n_err++; $display("FAIL timeout_back_to_idle: gnt1 after %0d cycles want 2", k); end
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      if (rvalid1) got = 1'b1;
    end
    n_vec++;
    if ({got, result1, err1} !== {1'b1, 64'd16, 1'b0}) begin
      n_err++; $display("FAIL timeout_next_txn: rvalid=%b result1=%0d err1=%b want 1/16/0", got, result1, err1);
    end
    n_vec++;
    if ({err0, result0} !== {1'b1, 64'd0}) begin
      n_err++; $display("FAIL timeout_port0_held: err0=%b result0=%0d want 1/0", err0, result0);
    end
  endtask

  task automatic test_reset_mid();
    bit seen_g, rv1_seen, got;
    int first;
    do_reset();
    mplier1 = 32'd6; mcand1 = 32'd7; req1 = 1'b1; seen_g = 1'b0; rv1_seen = 1'b0;
    for (int c = 0; c < 10 && !seen_g; c++) begin
      tick();
      if (gnt1) begin seen_g = 1'b1; req1 = 1'b0; end
    end
    repeat (5) begin
      tick();
      if (rvalid1) rv1_seen = 1'b1;
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({gnt0, gnt1, rvalid0, rvalid1, err0, err1, mul_start} !== 7'd0) begin
      n_err++; $display("FAIL midreset_strobes: got %b want 0000000", {gnt0, gnt1, rvalid0, rvalid1, err0, err1, mul_start});
    end
    n_vec++;
    if ({mul_multiplier, mul_multiplicand, result0, result1} !== 192'd0) begin
      n_err++; $display("FAIL midreset_data: operands %0d/%0d results %0d/%0d want all 0", mul_multiplier, mul_multiplicand, result0, result1);
    end
    mplier0 = 32'd2; mcand0 = 32'd3; mplier1 = 32'd4; mcand1 = 32'd5;
    req0 = 1'b1; req1 = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    first = -1;
    for (int c = 0; c < 10 && first < 0; c++) begin
      tick();
      if (rvalid1) rv1_seen = 1'b1;
      if (gnt0 || gnt1) begin first = gnt1 ? 1 : 0; req0 = 1'b0; req1 = 1'b0; end
    end
    n_vec++;
    if (first !== 0) begin n_err++; $display("FAIL midreset_first_port: got %0d want 0", first); end
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      if (rvalid1) rv1_seen = 1'b1;
      if (rvalid0) got = 1'b1;
    end
    n_vec++;
    if ({got, result0} !== {1'b1, 64'd6}) begin
      n_err++; $display("FAIL midreset_next_result: rvalid0=%b result0=%0d want 1/6", got, result0);
    end
    n_vec++;
    if (rv1_seen !== 1'b0) begin n_err++; $display("FAIL midreset_no_rvalid1: got %b want 0", rv1_seen); end
  endtask

  task automatic test_done_low();
    int ng, k;
    bit got;
    do_reset();
    hold_busy = 1'b1;
    mplier0 = 32'd12; mcand0 = 32'd12; req0 = 1'b1; ng = 0;
    repeat (10) begin
      tick();
      if (gnt0 || gnt1) ng++;
    end
    n_vec++;
    if (ng !== 0) begin n_err++; $display("FAIL donelow_no_gnt: got %0d grants want 0", ng); end
    hold_busy = 1'b0;
    k = -1;
    for (int c = 1; c <= 5 && k < 0; c++) begin
      tick();
      if (gnt0) begin k = c; req0 = 1'b0; end
    end
    n_vec++;
    if (k !== 1) begin n_err++; $display("FAIL donelow_gnt_delay: gnt0 after %0d cycles want 1", k); end
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      if (rvalid0) got = 1'b1;
    end
    n_vec++;
    if ({got, result0} !== {1'b1, 64'd144}) begin
      n_err++; $display("FAIL donelow_result0: rvalid0=%b result0=%0d want 1/144", got, result0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_both();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_done_low();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand width; result width is 2*WIDTH.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles in WAIT before abort.
REQ-003 clock  input  1  sole clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req0, req1  input  1 each  requester k wants a multiply; level-sensitive.
REQ-006 mplier0, mcand0, mplier1, mcand1  input  WIDTH each  requester k operands, valid while req_k=1.
REQ-007 gnt0, gnt1  output  1 each  one-cycle pulse; requester k operands captured, req_k may drop.
REQ-008 rvalid0, rvalid1  output  1 each  one-cycle pulse; result_k and err_k valid.
REQ-009 result0, result1  output  2*WIDTH each  product for requester k; holds until next rvalid_k.
REQ-010 err0, err1  output  1 each  accompanies rvalid_k; 1 means timeout abort, result_k=0.
REQ-011 mul_start  output  1  start strobe to shared multiplier.
REQ-012 mul_multiplier, mul_multiplicand  output  WIDTH each  operands to shared multiplier.
REQ-013 mul_result  input  2*WIDTH  multiplier product.
REQ-014 mul_done  input  1  multiplier idle/complete; 1 when idle, 0 while busy.

Function
REQ-015 States: IDLE, START, WAIT, RESP; encoding free; illegal states SHALL return to IDLE.
REQ-016 IDLE: if mul_done=1 and any req, grant one port, latch its operands into mul_multiplier/mul_multiplicand, record owner, pulse gnt_owner next cycle, go START.
REQ-017 IDLE with mul_done=0 SHALL grant nothing and stay IDLE.
REQ-018 Arbitration round-robin: single requester wins; both requesting -> port not served last wins; pointer after reset favours port 0.
REQ-019 START: mul_start=1 for exactly this one cycle, gnt_owner=1 same cycle, clear busy_seen and timeout counter, go WAIT.
REQ-020 WAIT: set busy_seen when mul_done=0; when busy_seen=1 and mul_done=1, capture mul_result into result_owner, err_owner=0, go RESP.
REQ-021 WAIT: timeout counter increments each cycle; reaching TIMEOUT before completion -> result_owner=0, err_owner=1, go RESP.
REQ-022 RESP: rvalid_owner=1 for this one cycle, update round-robin pointer to owner, go IDLE; no grant in RESP.
REQ-023 Latency (WIDTH=32, 16-iteration multiplier): rvalid_k asserted 19 cycles after gnt_k; in general 1 cycle after mul_done rises in WAIT.
REQ-024 Operands on mul_* outputs SHALL stay stable from START through RESP.
REQ-025 Requests arriving while not IDLE are held off (no gnt) and served in order per REQ-018 once IDLE.
REQ-026 A port never sees gnt and rvalid in the same cycle; the non-owner port's gnt/rvalid/result/err never change during a transaction.
REQ-027 At most one outstanding transaction; the same port may be re-granted the cycle after RESP if it still requests and wins.

Reset
REQ-028 reset_n=0 SHALL immediately force state IDLE, all gnt/rvalid/err/mul_start=0, result0/result1=0, mul operands=0, pointer to favour port 0, counters 0.
REQ-029 Reset mid-transaction discards it; no rvalid issued for it after release.
REQ-030 First grant possible in the first cycle after reset_n rises with mul_done=1.

Verification
REQ-031 req0 only, 35 x 17 -> gnt0 one pulse, mul_start one pulse, rvalid0 19 cycles after gnt0, result0=595, err0=0.
REQ-032 req0 and req1 together (35x63, 17x35) -> port 0 served first (2205), then port 1 (595); no overlap, gnt1 only after rvalid0.
REQ-033 Both held continuously for 4 transactions -> grant order 0,1,0,1.
REQ-034 Multiplier model never drops mul_done -> after TIMEOUT cycles rvalid0=1, err0=1, result0=0, state IDLE.
REQ-035 reset_n pulsed low 5 cycles after gnt1 -> outputs zero immediately, no rvalid1 afterward, next grant favours port 0.
REQ-036 mul_done held 0 in IDLE with req0=1 -> no gnt0 until mul_done=1.
